// File: rtl/simon_pkg.sv
// Shared types, z-sequence constants, configuration lookup and rotate helpers
// for the Simon cipher cores.
package simon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        DECRYPT = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] rounds;
        logic [2:0] zsel;
    } simon_cfg_t;

    localparam int MAXN = 64;
    typedef logic [MAXN-1:0] word_t;

    // Bit i of each constant is element i of the sequence.
    localparam logic [61:0] Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;
    localparam logic [61:0] Z1 = 62'b01011010000110010011111011100010101101000011001001111101110001;
    localparam logic [61:0] Z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;
    localparam logic [61:0] Z3 = 62'b11110000101100111001010001001000000111101001100011010111011011;
    localparam logic [61:0] Z4 = 62'b11110111001001010011000011101000000100011011010110011110001011;

    function automatic simon_cfg_t simon_cfg(input int n, input int m);
        simon_cfg_t c;
        case ({n[7:0], m[3:0]})
            {8'd16, 4'd4}: c = '{8'd32, 3'd0};
            {8'd24, 4'd3}: c = '{8'd36, 3'd0};
            {8'd24, 4'd4}: c = '{8'd36, 3'd1};
            {8'd32, 4'd3}: c = '{8'd42, 3'd2};
            {8'd32, 4'd4}: c = '{8'd44, 3'd3};
            {8'd48, 4'd2}: c = '{8'd52, 3'd2};
            {8'd48, 4'd3}: c = '{8'd54, 3'd3};
            {8'd64, 4'd2}: c = '{8'd68, 3'd2};
            {8'd64, 4'd3}: c = '{8'd69, 3'd3};
            {8'd64, 4'd4}: c = '{8'd72, 3'd4};
            default:       c = '{8'd44, 3'd3};
        endcase
        return c;
    endfunction

    function automatic logic [61:0] z_seq(input logic [2:0] sel);
        case (sel)
            3'd0:    return Z0;
            3'd1:    return Z1;
            3'd2:    return Z2;
            3'd3:    return Z3;
            3'd4:    return Z4;
            default: return Z3;
        endcase
    endfunction

    // Rotate the low w bits of v left by s; bits above w come back as zero.
    function automatic word_t rol(input word_t v, input int w, input int s);
        word_t one;
        word_t mask;
        one  = {{(MAXN-1){1'b0}}, 1'b1};
        mask = (w >= MAXN) ? '1 : ((one << w) - one);
        v    = v & mask;
        return ((v << s) | (v >> (w - s))) & mask;
    endfunction

    function automatic word_t ror(input word_t v, input int w, input int s);
        return rol(v, w, w - s);
    endfunction

endpackage

// File: rtl/simon_key_step.sv
// One Simon key-schedule step, forward (inverse=0) or backward (inverse=1);
// also returns the key window shifted by one in the matching direction.
module simon_key_step
    import simon_pkg::*;
#(
    parameter int n       = 32,
    parameter int m       = 4,
    parameter int zsel    = 3,
    parameter bit inverse = 1'b0
) (
    input  logic [n*m-1:0] window,
    input  logic [7:0]     idx,
    output logic [n-1:0]   key_new,
    output logic [n*m-1:0] win_next
);
    typedef logic [n-1:0] nword_t;

    // Forward window holds k[i..i+m-1]; inverse window holds k[i+1..i+m].
    localparam int A_W    = inverse ? m - 2 : m - 1;
    localparam int B_W    = inverse ? 0 : 1;
    localparam int BASE_W = inverse ? m - 1 : 0;
    localparam logic [61:0] ZC = z_seq(3'(zsel));

    nword_t     a_s, b_s, base_s, t0_s, t1_s, t2_s;
    logic [5:0] zi_s;

    assign a_s    = window[A_W*n +: n];
    assign b_s    = window[B_W*n +: n];
    assign base_s = window[BASE_W*n +: n];
    assign zi_s   = 6'((idx >= 8'd62) ? idx - 8'd62 : idx);

    assign t0_s = nword_t'(ror(word_t'(a_s), n, 3));
    assign t1_s = (m == 4) ? (t0_s ^ b_s) : t0_s;
    assign t2_s = t1_s ^ nword_t'(ror(word_t'(t1_s), n, 1));

    assign key_new = ~(base_s ^ t2_s ^ {{(n-1){1'b0}}, ZC[zi_s]} ^ {{(n-2){1'b0}}, 2'b11});

    if (inverse) begin : g_inv
        assign win_next = {window[n*(m-1)-1:0], key_new};
    end else begin : g_fwd
        assign win_next = {key_new, window[n*m-1:n]};
    end

endmodule

// File: rtl/simon_decrypt.sv
// Iterative Simon decryption core, one round per clock, round keys derived on the fly.
// Optional key cache skipping the forward expansion: define SIMON_DEC_KEYCACHE_EN.
module simon_decrypt
    import simon_pkg::*;
#(
    parameter int n = 32,
    parameter int m = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [n*m-1:0]   key,
    input  logic [2*n-1:0]   ciphertext,
    output logic [2*n-1:0]   plaintext,
    output logic             done
);
    typedef logic [n-1:0] nword_t;

    localparam simon_cfg_t CFG      = simon_cfg(n, m);
    localparam int         T        = int'(CFG.rounds);
    localparam int         ZSEL     = int'(CFG.zsel);
    localparam logic [7:0] LAST_EXP = 8'(T - m - 1);
    localparam logic [7:0] LAST_RND = 8'(T - 1);

    state_t         state_r;
    logic [n*m-1:0] win_r, win_fwd_s, win_inv_s, cwin_s;
    nword_t         x_r, y_r, f_s, rk_s, ynew_s, fwd_key_s, inv_key_s;
    logic [7:0]     cnt_r;
    logic           accept_s, hit_s;

    simon_key_step #(.n(n), .m(m), .zsel(ZSEL), .inverse(1'b0)) u_fwd (
        .window  (win_r),
        .idx     (cnt_r),
        .key_new (fwd_key_s),
        .win_next(win_fwd_s)
    );

    // Inverse step rebuilds k[r-m]; for r < m the result is never consumed.
    simon_key_step #(.n(n), .m(m), .zsel(ZSEL), .inverse(1'b1)) u_inv (
        .window  (win_r),
        .idx     (cnt_r - 8'(m)),
        .key_new (inv_key_s),
        .win_next(win_inv_s)
    );

    assign rk_s     = win_r[n*(m-1) +: n];
    assign f_s      = nword_t'(rol(word_t'(y_r), n, 1) & rol(word_t'(y_r), n, 8))
                    ^ nword_t'(rol(word_t'(y_r), n, 2));
    assign ynew_s   = x_r ^ f_s ^ rk_s;
    assign accept_s = en && ((state_r == IDLE) || (state_r == DONE));

`ifdef SIMON_DEC_KEYCACHE_EN
    logic [n*m-1:0] mkey_r, ckey_r, cwin_r;
    logic           cvalid_r;

    assign hit_s  = cvalid_r && (key == ckey_r);
    assign cwin_s = cwin_r;

    // Capture the tail of the schedule for the key that produced it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mkey_r   <= '0;
            ckey_r   <= '0;
            cwin_r   <= '0;
            cvalid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                mkey_r <= key;
            end
            if ((state_r == EXPAND) && (cnt_r == LAST_EXP)) begin
                ckey_r   <= mkey_r;
                cwin_r   <= win_fwd_s;
                cvalid_r <= 1'b1;
            end
        end
    end
`else
    assign hit_s  = 1'b0;
    assign cwin_s = '0;
`endif

    // Control FSM and datapath: expand forward, then run inverse rounds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            win_r     <= '0;
            x_r       <= '0;
            y_r       <= '0;
            cnt_r     <= 8'd0;
            plaintext <= '0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        x_r  <= ciphertext[2*n-1:n];
                        y_r  <= ciphertext[n-1:0];
                        done <= 1'b0;
                        if (hit_s) begin
                            win_r   <= cwin_s;
                            cnt_r   <= LAST_RND;
                            state_r <= DECRYPT;
                        end else begin
                            win_r   <= key;
                            cnt_r   <= 8'd0;
                            state_r <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    win_r <= win_fwd_s;
                    if (cnt_r == LAST_EXP) begin
                        cnt_r   <= LAST_RND;
                        state_r <= DECRYPT;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                DECRYPT: begin
                    x_r   <= y_r;
                    y_r   <= ynew_s;
                    win_r <= win_inv_s;
                    if (cnt_r == 8'd0) begin
                        plaintext <= {y_r, ynew_s};
                        done      <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_decrypt.sv
// Self-checking bench for simon_decrypt (64/128): known vectors, ignored starts,
// mid-run reset and randomized encrypt/decrypt loopback against a full-schedule model.
module tb_simon_decrypt;
    localparam int N = 32;
    localparam int M = 4;
    localparam int T = 44;
`ifdef SIMON_DEC_KEYCACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, en, done;
    logic [127:0] key;
    logic [63:0]  ciphertext, plaintext;

    int checks = 0;
    int errors = 0;

    logic [127:0] cached_key;
    bit           cached_valid;

    always #5 clk = ~clk;

    simon_decrypt #(.n(N), .m(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .key       (key),
        .ciphertext(ciphertext),
        .plaintext (plaintext),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] ff(input logic [31:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    // Full key schedule up front, then straight encryption or decryption.
    function automatic logic [63:0] ref_crypt(input logic [127:0] kk, input logic [63:0] blk, input bit decrypt);
        logic [31:0] k [0:T-1];
        logic [31:0] x, y, t;
        logic [63:0] z;
        z = 64'hfc2ce51207a635db;
        for (int i = 0; i < M; i++) k[i] = kk[32*i +: 32];
        for (int i = M; i < T; i++) begin
            t = rotl(k[i-1], 29) ^ k[i-3];
            t = t ^ rotl(t, 31);
            k[i] = ~k[i-4] ^ t ^ {31'd0, z[(i-M) % 62]} ^ 32'd3;
        end
        x = blk[63:32];
        y = blk[31:0];
        if (decrypt) begin
            for (int i = T - 1; i >= 0; i--) begin
                t = y;
                y = x ^ ff(y) ^ k[i];
                x = t;
            end
        end else begin
            for (int i = 0; i < T; i++) begin
                t = x;
                x = y ^ ff(x) ^ k[i];
                y = t;
            end
        end
        return {x, y};
    endfunction

    function automatic int exp_lat(input logic [127:0] k);
        return (CACHE && cached_valid && (k == cached_key)) ? T : (2 * T - M);
    endfunction

    // Start one operation; optionally poke en mid-run or pull reset at a given cycle.
    task automatic run_op(input logic [127:0] k, input logic [63:0] ct,
                          input int poke_at, input int rst_at, output int lat);
        @(negedge clk);
        key = k;
        ciphertext = ct;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        lat = 0;
        while (!done && lat < 300) begin
            if (lat == poke_at) begin
                en = 1'b1;
                key = {$urandom(), $urandom(), $urandom(), $urandom()};
                ciphertext = {$urandom(), $urandom()};
            end
            if (lat == poke_at + 3) en = 1'b0;
            if (lat == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            lat++;
        end
        en = 1'b0;
    endtask

    task automatic full_op(input string tag, input logic [127:0] k, input logic [63:0] ct,
                           input logic [63:0] exp_pt, input int poke_at);
        int lat;
        int want;
        want = exp_lat(k);
        run_op(k, ct, poke_at, -1, lat);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_pt"}, plaintext, exp_pt);
        check({tag, "_lat"}, 64'(lat), 64'(want));
        cached_key = k;
        cached_valid = 1'b1;
    endtask

    initial begin
        int lat;
        logic [127:0] k, kchain;
        logic [63:0]  p;

        rst_n = 1'b0;
        en = 1'b0;
        key = '0;
        ciphertext = '0;
        cached_valid = 1'b0;
        cached_key = '0;
        repeat (3) @(negedge clk);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_pt", plaintext, 64'd0);
        rst_n = 1'b1;

        full_op("vec1", 128'h1b1a1918131211100b0a090803020100, 64'h44c8fc20b9dfa07a,
                64'h656b696c20646e75, -1);
        full_op("vec2", 128'h0123456789ABCDEF0123456789ABCDEF, 64'hE0EEA3F009ED2BC7,
                64'hFEDCBA9876543210, -1);

        kchain = 128'hFEDCBA98765432100123456789ABCDEF;
        full_op("chain1", kchain, 64'h06372B3E88230685, 64'h823A057D5B933604, -1);
        full_op("chain2", kchain, plaintext, 64'h34BE744934FABB4E, -1);
        full_op("chain3", kchain, plaintext, 64'h1234567890ABCDEF, -1);

        full_op("ignore_en", 128'h1b1a1918131211100b0a090803020100, 64'h44c8fc20b9dfa07a,
                64'h656b696c20646e75, 60);

        run_op(kchain, 64'h06372B3E88230685, -1, 49, lat);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_pt", plaintext, 64'd0);
        cached_valid = 1'b0;
        full_op("after_rst", 128'h0123456789ABCDEF0123456789ABCDEF, 64'hE0EEA3F009ED2BC7,
                64'hFEDCBA9876543210, -1);

        k = '0;
        for (int i = 0; i < 200; i++) begin
            if ((i % 4) != 1) k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom()};
            full_op("loop", k, ref_crypt(k, p, 1'b0), p, -1);
            if (i % 25 == 0) check("loop_model", plaintext, ref_crypt(k, ref_crypt(k, p, 1'b0), 1'b1));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
